// File: rtl/dma_seq.sv
// Block-copy DMA sequencer: walks SRAM words into the UART DMA engine one element at a time.
// Optional WAIT_HI timeout with sticky err flag is enabled by defining DMA_SEQ_TIMEOUT_EN.
module dma_seq #(
    parameter int SRAM_ADDR_W = 10,
    parameter int HOST_ADDR_W = 7,
    parameter int LEN_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [SRAM_ADDR_W-1:0] cmd_sram_addr,
    input  logic [HOST_ADDR_W-1:0] cmd_host_addr,
    input  logic [LEN_W-1:0]       cmd_len,
    output logic                   sram_rd_en,
    output logic [SRAM_ADDR_W-1:0] sram_rd_addr,
    input  logic [17:0]            sram_rd_dat,
    output logic [17:0]            dma_dat_w,
    output logic [HOST_ADDR_W-1:0] dma_dat_addr,
    output logic                   dma_we,
    input  logic                   dma_busy,
    output logic                   active,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [SRAM_ADDR_W-1:0] r_cur_sram;
    logic [HOST_ADDR_W-1:0] r_cur_host;
    logic [LEN_W-1:0]       r_remaining;

`ifdef DMA_SEQ_TIMEOUT_EN
    logic [2:0]             r_to_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            cmd_ready    <= 1'b1;
            sram_rd_en   <= 1'b0;
            sram_rd_addr <= '0;
            dma_dat_w    <= '0;
            dma_dat_addr <= '0;
            dma_we       <= 1'b0;
            active       <= 1'b0;
            done         <= 1'b0;
            r_cur_sram   <= '0;
            r_cur_host   <= '0;
            r_remaining  <= '0;
`ifdef DMA_SEQ_TIMEOUT_EN
            err          <= 1'b0;
            r_to_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_cur_sram  <= cmd_sram_addr;
                        r_cur_host  <= cmd_host_addr;
                        r_remaining <= cmd_len;
                        cmd_ready   <= 1'b0;
                        active      <= 1'b1;
`ifdef DMA_SEQ_TIMEOUT_EN
                        err         <= 1'b0;
`endif
                        if (cmd_len == '0) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            sram_rd_en   <= 1'b1;
                            sram_rd_addr <= cmd_sram_addr;
                            r_state      <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    sram_rd_en <= 1'b0;
                    r_state    <= S_LATCH;
                end
                S_LATCH: begin
                    // Data/address hold until the next element's LATCH; the engine samples late.
                    dma_dat_w    <= sram_rd_dat;
                    dma_dat_addr <= r_cur_host;
                    dma_we       <= 1'b1;
                    r_state      <= S_ISSUE;
                end
                S_ISSUE: begin
                    dma_we  <= 1'b0;
`ifdef DMA_SEQ_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (dma_busy) begin
                        r_state <= S_WAIT_LO;
`ifdef DMA_SEQ_TIMEOUT_EN
                    end else if (r_to_cnt == 3'd7) begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 3'd1;
`endif
                    end
                end
                S_WAIT_LO: begin
                    if (!dma_busy) begin
                        if (r_remaining == LEN_W'(1)) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_remaining  <= r_remaining - LEN_W'(1);
                            r_cur_sram   <= r_cur_sram + SRAM_ADDR_W'(1);
                            r_cur_host   <= r_cur_host + HOST_ADDR_W'(1);
                            sram_rd_en   <= 1'b1;
                            sram_rd_addr <= r_cur_sram + SRAM_ADDR_W'(1);
                            r_state      <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    active    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
